id_imm_stage: RTL

ID_IMM_STAGE -- requirements
Module: id_imm_stage

---
 rtl/id_imm_stage_pkg.sv | 24 ++
 rtl/id_imm_stage_decode.sv | 62 ++++++
 rtl/id_imm_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/id_imm_stage_pkg.sv
// Shared definitions for the I-type decode stage: opcodes, width options and
// the stage state encoding.
package id_imm_stage_pkg;

    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // Supported datapath widths.
    localparam int DATA_W_NARROW = 32;
    localparam int DATA_W_WIDE   = 64;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_STALL = 2'd2
    } stage_state_t;

endpackage

// File: rtl/id_imm_stage_decode.sv
// Combinational I-type decode: register read request, operands and writeback
// fields for one instruction word.
module imm_itype_decode
    import id_imm_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       inst,
    input  logic [DATA_W-1:0] rs_val,
    output logic              reg_read_en,
    output logic [4:0]        reg_addr,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic              wen,
    output logic [4:0]        waddr,
    output logic              is_itype
);

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [31:0] lui_word;

    assign opcode   = inst[31:26];
    assign rs       = inst[25:21];
    assign rt       = inst[20:16];
    assign imm      = inst[15:0];
    assign lui_word = {imm, 16'h0000};

    // Opcode classification and immediate extension; LUI reads no register.
    always_comb begin
        is_itype    = 1'b0;
        reg_read_en = 1'b0;
        op2         = '0;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: begin
                is_itype    = 1'b1;
                reg_read_en = 1'b1;
                op2         = DATA_W'(imm);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                is_itype    = 1'b1;
                reg_read_en = 1'b1;
                op2         = DATA_W'($signed(imm));
            end
            OP_LUI: begin
                is_itype    = 1'b1;
                op2         = DATA_W'($signed(lui_word));
            end
            default: begin
                is_itype    = 1'b0;
            end
        endcase
    end

    assign reg_addr = reg_read_en ? rs : 5'd0;
    assign op1      = reg_read_en ? rs_val : '0;
    assign wen      = is_itype;
    assign waddr    = is_itype ? rt : 5'd0;

endmodule

// File: rtl/id_imm_stage.sv
// I-type decode stage: one-deep output register with valid/ready handshake,
// load-use stall detection and a saturating stall-cycle counter.
module id_imm_stage
    import id_imm_stage_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter bit LOAD_USE_CHECK = 1'b1,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            inst,
    output logic                   reg_read_en,
    output logic [4:0]             reg_addr,
    input  logic [DATA_W-1:0]      rs_val,
    input  logic                   ex_load_pending,
    input  logic [4:0]             ex_load_addr,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_op1,
    output logic [DATA_W-1:0]      out_op2,
    output logic                   out_wen,
    output logic [4:0]             out_waddr,
    output logic                   out_is_itype,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [DATA_W-1:0] dec_op1;
    logic [DATA_W-1:0] dec_op2;
    logic              dec_wen;
    logic [4:0]        dec_waddr;
    logic              dec_is_itype;
    logic              hazard;
    logic              accept;
    logic              valid_q;
    logic              valid_next;
    stage_state_t      state;
    stage_state_t      state_next;

    imm_itype_decode #(.DATA_W(DATA_W)) u_decode (
        .inst        (inst),
        .rs_val      (rs_val),
        .reg_read_en (reg_read_en),
        .reg_addr    (reg_addr),
        .op1         (dec_op1),
        .op2         (dec_op2),
        .wen         (dec_wen),
        .waddr       (dec_waddr),
        .is_itype    (dec_is_itype)
    );

    // rs of zero never waits on a load: register zero is hard-wired.
    assign hazard = LOAD_USE_CHECK && in_valid && reg_read_en && ex_load_pending
                    && (ex_load_addr == inst[25:21]) && (inst[25:21] != 5'd0);

    assign in_ready  = !rst && !hazard && !flush && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_FULL) || ((state == ST_STALL) && valid_q);

    // State and held-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            valid_q <= valid_next;
        end
    end

    // Next-state logic; flush overrides hazard, hazard overrides handshake.
    always_comb begin
        valid_next = valid_q;
        state_next = state;
        if (flush)
            valid_next = 1'b0;
        else if (accept)
            valid_next = 1'b1;
        else if (out_ready)
            valid_next = 1'b0;

        case (state)
            ST_EMPTY: if (accept) state_next = ST_FULL;
            ST_FULL:  if (out_ready && !accept) state_next = ST_EMPTY;
            ST_STALL: state_next = valid_next ? ST_FULL : ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase

        if (hazard)
            state_next = ST_STALL;
        if (flush)
            state_next = ST_EMPTY;
    end

    // Output register: zeroed on reset/flush, loaded on accept, else held.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_op1      <= '0;
            out_op2      <= '0;
            out_wen      <= 1'b0;
            out_waddr    <= 5'd0;
            out_is_itype <= 1'b0;
        end else if (accept) begin
            out_op1      <= dec_op1;
            out_op2      <= dec_op2;
            out_wen      <= dec_wen;
            out_waddr    <= dec_waddr;
            out_is_itype <= dec_is_itype;
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (hazard && (stall_cnt != {STALL_CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule
